// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one line-memory port among NCH cache
// channels, with a RESP_STAGES-deep registered return path.
module mem_arbiter #(
  parameter int NCH         = 2,
  parameter int AW          = 28,
  parameter int DW          = 128,
  parameter int RESP_STAGES = 1
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic [NCH-1:0]           ch_read,
  input  logic [NCH-1:0]           ch_write,
  input  logic [NCH*AW-1:0]        ch_addr,
  input  logic [NCH*DW-1:0]        ch_wdata,
  output logic [DW-1:0]            ch_rdata,
  output logic [NCH-1:0]           ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic [$clog2(NCH)-1:0]   grant_id
);

  localparam int GW = $clog2(NCH);
  localparam int PS = (RESP_STAGES > 0) ? RESP_STAGES : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [PS-1:0] rdy_q, rdy_d;
  logic [DW-1:0] dat_q [PS];
  logic [DW-1:0] dat_d [PS];

  logic [NCH-1:0] req;
  logic           found;
  logic [GW-1:0]  pick;
  logic [GW-1:0]  c;
  logic           resp_in;

  assign req     = ch_read | ch_write;
  assign resp_in = (state_q == ISSUE) && mem_ready;

  // Cyclic search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    c     = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = GW'((int'(last_q) + k) % NCH);
      if (!found && req[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          last_d      = pick;
          grant_d     = pick;
          mem_write_d = ch_write[pick];
          mem_read_d  = !ch_write[pick];
          addr_d      = ch_addr[pick*AW +: AW];
          wdata_d     = ch_wdata[pick*DW +: DW];
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (RESP_STAGES > 0) state_d = DRAIN;
          else                 state_d = IDLE;
        end
      end
      DRAIN: begin
        if (rdy_q[PS-1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return pipe; the data stages only load with a valid, so the
  // last stage holds the most recent line.
  always_comb begin
    rdy_d    = '0;
    rdy_d[0] = resp_in;
    for (int s = 1; s < PS; s++) rdy_d[s] = rdy_q[s-1];
    dat_d = dat_q;
    if (resp_in) dat_d[0] = mem_rdata;
    for (int s = 1; s < PS; s++) begin
      if (rdy_q[s-1]) dat_d[s] = dat_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      last_q      <= GW'(NCH - 1);
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdy_q       <= '0;
      for (int s = 0; s < PS; s++) dat_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdy_q       <= rdy_d;
      dat_q       <= dat_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

  generate
    if (RESP_STAGES == 0) begin : g_comb
      assign ch_rdata = mem_rdata;
      assign ch_ready = (resp_in && !proc_reset) ?
                        (NCH'(1) << grant_q) : '0;
    end else begin : g_pipe
      assign ch_rdata = dat_q[PS-1];
      assign ch_ready = rdy_q[PS-1] ? (NCH'(1) << grant_q) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand sequences, a RESP_STAGES sweep and a
// randomized run against a round-robin reference model.
module tb_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int RS  = 1;
  localparam int GW  = 2;
  localparam int SW_RS [3] = '{0, 1, 3};

  logic              clk = 1'b0;
  logic              proc_reset;
  logic [NCH-1:0]    ch_read, ch_write;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ch_rdata;
  logic [NCH-1:0]    ch_ready;
  logic              mem_read, mem_write;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic [GW-1:0]     grant_id;

  logic              sw_reset;
  logic [1:0]        sw_read, sw_write;
  logic [2*AW-1:0]   sw_addr;
  logic [2*DW-1:0]   sw_wdata;
  logic [DW-1:0]     sw_rdata_in;
  logic              sw_ready_in;
  logic [DW-1:0]     sw_ch_rdata [3];
  logic [1:0]        sw_ch_ready [3];
  logic              sw_mread [3];
  logic              sw_mwrite [3];
  logic              sw_busy [3];
  logic [AW-1:0]     sw_maddr [3];
  logic [DW-1:0]     sw_mwdata [3];
  logic              sw_gid [3];

  always #5 clk = ~clk;

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RESP_STAGES(RS)) u_dut (
    .clk(clk), .proc_reset(proc_reset),
    .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_ready(ch_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.NCH(2), .AW(AW), .DW(DW), .RESP_STAGES(0)) u_sw0 (
    .clk(clk), .proc_reset(sw_reset),
    .ch_read(sw_read), .ch_write(sw_write),
    .ch_addr(sw_addr), .ch_wdata(sw_wdata),
    .ch_rdata(sw_ch_rdata[0]), .ch_ready(sw_ch_ready[0]),
    .mem_read(sw_mread[0]), .mem_write(sw_mwrite[0]),
    .mem_addr(sw_maddr[0]), .mem_wdata(sw_mwdata[0]),
    .mem_rdata(sw_rdata_in), .mem_ready(sw_ready_in),
    .busy(sw_busy[0]), .grant_id(sw_gid[0])
  );

  mem_arbiter #(.NCH(2), .AW(AW), .DW(DW), .RESP_STAGES(1)) u_sw1 (
    .clk(clk), .proc_reset(sw_reset),
    .ch_read(sw_read), .ch_write(sw_write),
    .ch_addr(sw_addr), .ch_wdata(sw_wdata),
    .ch_rdata(sw_ch_rdata[1]), .ch_ready(sw_ch_ready[1]),
    .mem_read(sw_mread[1]), .mem_write(sw_mwrite[1]),
    .mem_addr(sw_maddr[1]), .mem_wdata(sw_mwdata[1]),
    .mem_rdata(sw_rdata_in), .mem_ready(sw_ready_in),
    .busy(sw_busy[1]), .grant_id(sw_gid[1])
  );

  mem_arbiter #(.NCH(2), .AW(AW), .DW(DW), .RESP_STAGES(3)) u_sw3 (
    .clk(clk), .proc_reset(sw_reset),
    .ch_read(sw_read), .ch_write(sw_write),
    .ch_addr(sw_addr), .ch_wdata(sw_wdata),
    .ch_rdata(sw_ch_rdata[2]), .ch_ready(sw_ch_ready[2]),
    .mem_read(sw_mread[2]), .mem_write(sw_mwrite[2]),
    .mem_addr(sw_maddr[2]), .mem_wdata(sw_mwdata[2]),
    .mem_rdata(sw_rdata_in), .mem_ready(sw_ready_in),
    .busy(sw_busy[2]), .grant_id(sw_gid[2])
  );

  typedef struct {
    int            ch;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit       rst;
    bit [3:0] rd;
    bit [3:0] wr;
    int       ch;
    bit       wr_op;
  } vec_t;

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            lat = 1;
  int            cnt = 0;
  bit            resp_en = 1'b1;
  bit            rand_lat = 1'b0;
  bit            prev_req = 1'b0;
  int            resp_cyc = -100;
  logic [DW-1:0] last_resp = '0;
  txn_t          log_q [$];

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic logic [AW-1:0] addr_of(int ch);
    return AW'(28'h0000100 + ch);
  endfunction

  function automatic logic [DW-1:0] wdat_of(int ch);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(ch);
    return {w, w, w, w};
  endfunction

  function automatic int rr_pick(int last, logic [NCH-1:0] r);
    for (int d = 1; d <= NCH; d++) begin
      if (r[(last + d) % NCH]) return (last + d) % NCH;
    end
    return -1;
  endfunction

  task automatic set_pattern();
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW]  = addr_of(i);
      ch_wdata[i*DW +: DW] = wdat_of(i);
    end
  endtask

  // One clock: memory responder for the main DUT plus transaction log.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (resp_en) begin
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          last_resp = mem_rdata;
          resp_cyc  = cyc;
          cnt       = 0;
          if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
    if ((mem_read || mem_write) && !prev_req)
      log_q.push_back('{int'(grant_id), mem_write, mem_addr, mem_wdata});
    prev_req = mem_read || mem_write;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    ch_read    = '0;
    ch_write   = '0;
    mem_ready  = 1'b0;
    cnt        = 0;
    step();
    step();
    proc_reset = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    for (int i = 0; i < 40 && busy; i++) step();
    chk(nm, busy, 0);
  endtask

  vec_t vt [10];
  int   first, kc;
  int   rc [3];
  int   bl [3];
  int   g, gi, m_last, cur;
  bit   cur_wr, got, bad, idle_req;
  txn_t tx;
  logic [NCH-1:0] exp_rdy;
  logic [DW-1:0]  beef;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 4'b0001, 4'b0000, 0, 1'b0};
    vt[1] = '{1'b0, 4'b0011, 4'b0000, 1, 1'b0};
    vt[2] = '{1'b0, 4'b0011, 4'b0000, 0, 1'b0};
    vt[3] = '{1'b1, 4'b0000, 4'b1000, 3, 1'b1};
    vt[4] = '{1'b1, 4'b0110, 4'b0000, 1, 1'b0};
    vt[5] = '{1'b0, 4'b1001, 4'b0000, 3, 1'b0};
    vt[6] = '{1'b0, 4'b0100, 4'b0100, 2, 1'b1};
    vt[7] = '{1'b0, 4'b0001, 4'b0010, 0, 1'b0};
    vt[8] = '{1'b0, 4'b0000, 4'b1110, 1, 1'b1};
    vt[9] = '{1'b1, 4'b1111, 4'b0000, 0, 1'b0};

    beef = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    mem_rdata   = '0;
    sw_reset    = 1'b1;
    sw_read     = '0;
    sw_write    = '0;
    sw_addr     = '0;
    sw_wdata    = '0;
    sw_rdata_in = '0;
    sw_ready_in = 1'b0;
    set_pattern();
    do_reset();

    chk("rst mem_read", mem_read, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst ch_rdata", ch_rdata, 0);
    chk("rst ch_ready", ch_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst grant_id", grant_id, 0);

    // Single read on ch1 through RESP_STAGES 0, 1 and 3 side by side.
    sw_reset = 1'b0;
    sw_addr[AW +: AW] = 28'h0000123;
    sw_read = 2'b10;
    first = -1;
    kc = -1;
    rc = '{-1, -1, -1};
    bl = '{-1, -1, -1};
    for (int i = 0; i < 30; i++) begin
      step();
      sw_ready_in = 1'b0;
      if (sw_mread[1] && first < 0) begin
        first = cyc;
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("sw%0d mem_read", SW_RS[j]), sw_mread[j], 1);
          chk($sformatf("sw%0d mem_addr", SW_RS[j]), sw_maddr[j], 28'h0000123);
        end
      end
      if (first >= 0 && cyc == first + 3) begin
        sw_ready_in = 1'b1;
        sw_rdata_in = beef;
        kc = cyc;
      end
      #1;
      for (int j = 0; j < 3; j++) begin
        if (sw_ch_ready[j] != 0 && rc[j] < 0) begin
          rc[j] = cyc;
          chk($sformatf("sw%0d ch_ready", SW_RS[j]), sw_ch_ready[j], 2'b10);
          chk($sformatf("sw%0d ch_rdata", SW_RS[j]), sw_ch_rdata[j], beef);
        end
        if (rc[j] >= 0 && !sw_busy[j] && bl[j] < 0) bl[j] = cyc;
      end
      if (kc >= 0 && cyc > kc) sw_read = 2'b00;
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("sw%0d ready delay", SW_RS[j]), rc[j] - kc, SW_RS[j]);
      chk($sformatf("sw%0d busy drop", SW_RS[j]), bl[j] - rc[j], 1);
    end

    // Vector table: first grant and op for a request pattern.
    for (int v = 0; v < 10; v++) begin
      if (vt[v].rst) do_reset();
      ch_read  = vt[v].rd;
      ch_write = vt[v].wr;
      step();
      chk($sformatf("v%0d grant_id", v), grant_id, vt[v].ch);
      chk($sformatf("v%0d mem_write", v), mem_write, vt[v].wr_op);
      chk($sformatf("v%0d mem_read", v), mem_read, !vt[v].wr_op);
      chk($sformatf("v%0d mem_addr", v), mem_addr, addr_of(vt[v].ch));
      chk($sformatf("v%0d mem_wdata", v), mem_wdata, wdat_of(vt[v].ch));
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        if (ch_ready != 0) got = 1'b1;
      end
      chk($sformatf("v%0d ch_ready", v), ch_ready, 4'b0001 << vt[v].ch);
      if (!vt[v].wr_op)
        chk($sformatf("v%0d ch_rdata", v), ch_rdata, last_resp);
      ch_read  = '0;
      ch_write = '0;
      wait_idle($sformatf("v%0d idle", v));
    end

    // Contention: ch0 read and ch1 write from reset.
    do_reset();
    log_q.delete();
    ch_read  = 4'b0001;
    ch_write = 4'b0010;
    for (int i = 0; i < 80; i++) begin
      step();
      if (ch_ready[0]) ch_read[0] = 1'b0;
      if (ch_ready[1]) ch_write[1] = 1'b0;
      if ((ch_read | ch_write) == 0 && !busy) break;
    end
    chk("cont count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("cont first ch", log_q[0].ch, 0);
      chk("cont first op", log_q[0].wr, 0);
      chk("cont first addr", log_q[0].addr, addr_of(0));
      chk("cont second ch", log_q[1].ch, 1);
      chk("cont second op", log_q[1].wr, 1);
      chk("cont second wdata", log_q[1].wdata, wdat_of(1));
    end

    // Round-robin with every channel requesting continuously.
    do_reset();
    log_q.delete();
    ch_read = 4'b1111;
    for (int i = 0; i < 200 && log_q.size() < 8; i++) step();
    ch_read = '0;
    chk("rr count", log_q.size() >= 8, 1);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk($sformatf("rr grant %0d", i), log_q[i].ch, i % NCH);
    wait_idle("rr idle");

    // mem_ready while idle is ignored.
    resp_en   = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ch_ready != 0 || busy) bad = 1'b1;
    end
    chk("stray ready ignored", bad, 0);

    // Reset while ch0's read is in ISSUE.
    ch_read = 4'b0001;
    step();
    chk("abort mem_read", mem_read, 1);
    step();
    proc_reset = 1'b1;
    ch_read = '0;
    step();
    chk("abort mem_read off", mem_read, 0);
    chk("abort mem_write", mem_write, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort mem_wdata", mem_wdata, 0);
    chk("abort ch_rdata", ch_rdata, 0);
    chk("abort ch_ready", ch_ready, 0);
    chk("abort busy", busy, 0);
    chk("abort grant_id", grant_id, 0);
    proc_reset = 1'b0;
    ch_read = 4'b0011;
    step();
    chk("post-abort grant", grant_id, 0);
    chk("post-abort mem_read", mem_read, 1);
    chk("post-abort mem_addr", mem_addr, addr_of(0));
    ch_read = '0;
    cnt = 0;
    resp_en = 1'b1;
    wait_idle("post-abort idle");

    // Randomized traffic against the reference model.
    do_reset();
    log_q.delete();
    m_last   = NCH - 1;
    cur      = 0;
    cur_wr   = 1'b0;
    idle_req = 1'b0;
    resp_cyc = -100;
    rand_lat = 1'b1;
    for (int t = 0; t < 600; t++) begin
      step();
      if (idle_req) chk("rand grant taken", log_q.size() != 0, 1);
      if (log_q.size() != 0) begin
        tx = log_q.pop_front();
        g  = rr_pick(m_last, ch_read | ch_write);
        gi = (g < 0) ? 0 : g;
        chk("rand grant", tx.ch, g);
        chk("rand op", tx.wr, ch_write[gi]);
        chk("rand addr", tx.addr, ch_addr[gi*AW +: AW]);
        chk("rand wdata", tx.wdata, ch_wdata[gi*DW +: DW]);
        m_last = gi;
        cur    = gi;
        cur_wr = ch_write[gi];
      end
      exp_rdy = (cyc == resp_cyc + RS) ? (4'b0001 << cur) : 4'b0000;
      if (exp_rdy != 0 || ch_ready != 0) begin
        chk("rand ch_ready", ch_ready, exp_rdy);
        if (exp_rdy != 0 && !cur_wr) chk("rand ch_rdata", ch_rdata, last_resp);
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_ready[i]) begin
          ch_read[i]  = 1'b0;
          ch_write[i] = 1'b0;
        end else if (!(ch_read[i] || ch_write[i]) &&
                     $urandom_range(0, 3) == 0) begin
          ch_read[i]  = $urandom_range(0, 1) == 1;
          ch_write[i] = !ch_read[i] || ($urandom_range(0, 3) == 0);
          ch_addr[i*AW +: AW]  = AW'($urandom);
          ch_wdata[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      idle_req = !busy && ((ch_read | ch_write) != 0);
    end
    ch_read  = '0;
    ch_write = '0;
    wait_idle("rand idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
